// File: rtl/oqpsk_rx_deserializer_pkg.sv
// Shared typedefs for the OQPSK transmit/receive datapaths.
// The rx state enum sits beside the transmit one so both FSMs share a single source.
package oqpsk_rx_deserializer_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_PREAMBLE,
        TX_PAYLOAD
    } transmission_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_RECEIVE,
        RX_DRAIN
    } rx_state_t;

    localparam int FRAME_LEN_W = 16;

    // A sample that is zero or positive decides a 1; a negative sample decides a 0.
    function automatic logic sign_to_bit(input logic sign);
        return ~sign;
    endfunction

endpackage

// File: rtl/oqpsk_rx_deserializer_if.sv
// AXI-Stream pair for the OQPSK deserializer: s_axis carries I/Q samples in, m_axis carries words out.
// The slave modport is the deserializer's view; master is the environment that feeds and drains it.
interface oqpsk_rx_deserializer_if #(
    parameter int SAMPLE_WIDTH = 12,
    parameter int TDATA_WIDTH  = 16
);
    logic [2*SAMPLE_WIDTH-1:0] s_axis_tdata;
    logic                      s_axis_tvalid;
    logic                      s_axis_tready;
    logic                      s_axis_tlast;
    logic [TDATA_WIDTH-1:0]    m_axis_tdata;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;
    logic                      m_axis_tlast;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/oqpsk_rx_bit_slicer.sv
// Hard-decision slicer: turns I/Q sample signs into bits and collects them into one interleaved word.
// The word output carries the Q bit being captured this cycle, so the caller can register it with no extra delay.
module oqpsk_rx_bit_slicer
    import oqpsk_rx_deserializer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 12,
    parameter int N            = 8,
    parameter int BW           = 3
) (
    input  logic                      aclk,
    input  logic                      sresetn,
    input  logic [2*SAMPLE_WIDTH-1:0] sample,
    input  logic                      cap_i,
    input  logic                      cap_q,
    input  logic [BW-1:0]             i_idx,
    input  logic [BW-1:0]             q_idx,
    output logic [2*N-1:0]            word
);
    logic [N-1:0] i_bits;
    logic [N-1:0] q_bits;
    logic         i_dec;
    logic         q_dec;
    logic         unused_mag;

    assign i_dec      = sign_to_bit(sample[SAMPLE_WIDTH-1]);
    assign q_dec      = sign_to_bit(sample[2*SAMPLE_WIDTH-1]);
    assign unused_mag = ^{sample[2*SAMPLE_WIDTH-2:SAMPLE_WIDTH], sample[SAMPLE_WIDTH-2:0]};

    always_ff @(posedge aclk) begin
        if (!sresetn) begin
            i_bits <= '0;
            q_bits <= '0;
        end else begin
            if (cap_i) i_bits[i_idx] <= i_dec;
            if (cap_q) q_bits[q_idx] <= q_dec;
        end
    end

    // Even bits carry I, odd bits carry Q; the in-flight Q decision bypasses its register.
    always_comb begin
        word = '0;
        for (int k = 0; k < N; k++) begin
            word[2*k]   = i_bits[k];
            word[2*k+1] = (cap_q && q_idx == BW'(k)) ? q_dec : q_bits[k];
        end
    end

endmodule

// File: rtl/oqpsk_rx_deserializer.sv
// OQPSK receive deserializer: slices oversampled I/Q samples into interleaved bit words framed by start/tlast.
// Optional OQPSK_RX_ERR_CNT_EN adds a saturating err_count output counting frame_err pulses.
module oqpsk_rx_deserializer
    import oqpsk_rx_deserializer_pkg::*;
#(
    parameter int SAMPLES_PER_SYMBOL     = 4,
    parameter int C_M00_AXIS_TDATA_WIDTH = 16,
    parameter int SAMPLE_WIDTH           = 12
) (
    input  logic                       aclk,
    input  logic                       sresetn,
    input  logic                       start,
    input  logic [FRAME_LEN_W-1:0]     frame_words,
    oqpsk_rx_deserializer_if.slave     axis,
    output logic                       frame_err,
    output logic                       busy
`ifdef OQPSK_RX_ERR_CNT_EN
    ,
    output logic [15:0]                err_count
`endif
);
    localparam int N   = C_M00_AXIS_TDATA_WIDTH / 2;
    localparam int SCW = $clog2(SAMPLES_PER_SYMBOL);
    localparam int BW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [SCW-1:0] SC_LAST  = SCW'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [SCW-1:0] SC_MID   = SCW'(SAMPLES_PER_SYMBOL / 2);
    localparam logic [BW-1:0]  BIT_LAST = BW'(N - 1);

    rx_state_t                   state, state_nxt;
    logic [SCW-1:0]              sample_cnt;
    logic [BW-1:0]               bit_cnt;
    logic [FRAME_LEN_W-1:0]      word_cnt;
    logic [FRAME_LEN_W-1:0]      frame_len;
    logic                        accept, in_rx, word_done, last_word, early_last;
    logic                        cap_i, cap_q;
    logic [BW-1:0]               q_idx;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] word;

    assign accept    = axis.s_axis_tvalid && axis.s_axis_tready;
    assign in_rx     = accept && (state == RX_RECEIVE);
    // Q of the previous symbol lands on sample 0, so a word finishes on the first sample of the next word.
    assign word_done = in_rx && sample_cnt == '0 && bit_cnt == '0 && word_cnt != '0;
    assign last_word = (word_cnt == frame_len);
    assign early_last = in_rx && axis.s_axis_tlast && !(word_done && last_word);
    assign cap_i     = in_rx && sample_cnt == SC_MID;
    assign cap_q     = in_rx && sample_cnt == '0 && (bit_cnt != '0 || word_cnt != '0);
    assign q_idx     = (bit_cnt == '0) ? BIT_LAST : bit_cnt - 1'b1;

    always_ff @(posedge aclk) begin
        if (!sresetn) state <= RX_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:    if (start && frame_words != '0) state_nxt = RX_RECEIVE;
            RX_RECEIVE: begin
                if (early_last)                  state_nxt = RX_IDLE;
                else if (word_done && last_word) state_nxt = axis.s_axis_tlast ? RX_IDLE : RX_DRAIN;
            end
            RX_DRAIN:   if (accept && axis.s_axis_tlast) state_nxt = RX_IDLE;
            default:    state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        busy               = (state != RX_IDLE);
        axis.s_axis_tready = busy && !(axis.m_axis_tvalid && !axis.m_axis_tready);
    end

    always_ff @(posedge aclk) begin
        if (!sresetn)                               frame_len <= '0;
        else if (state == RX_IDLE && start)         frame_len <= frame_words;
    end

    always_ff @(posedge aclk) begin
        if (!sresetn || state == RX_IDLE) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
        end else if (in_rx) begin
            if (sample_cnt == SC_LAST) begin
                sample_cnt <= '0;
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt  <= '0;
                    word_cnt <= word_cnt + 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end

    oqpsk_rx_bit_slicer #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .N            (N),
        .BW           (BW)
    ) u_slicer (
        .aclk    (aclk),
        .sresetn (sresetn),
        .sample  (axis.s_axis_tdata),
        .cap_i   (cap_i),
        .cap_q   (cap_q),
        .i_idx   (bit_cnt),
        .q_idx   (q_idx),
        .word    (word)
    );

    // Input is stalled while a word waits, so a new word only loads into a free or departing slot.
    always_ff @(posedge aclk) begin
        if (!sresetn) begin
            axis.m_axis_tvalid <= 1'b0;
            axis.m_axis_tlast  <= 1'b0;
            axis.m_axis_tdata  <= '0;
            frame_err          <= 1'b0;
        end else begin
            frame_err <= early_last;
            if (axis.m_axis_tvalid && axis.m_axis_tready) axis.m_axis_tvalid <= 1'b0;
            if (word_done && !early_last) begin
                axis.m_axis_tdata  <= word;
                axis.m_axis_tvalid <= 1'b1;
                axis.m_axis_tlast  <= last_word;
            end
        end
    end

`ifdef OQPSK_RX_ERR_CNT_EN
    always_ff @(posedge aclk) begin
        if (!sresetn)                            err_count <= '0;
        else if (frame_err && err_count != '1)   err_count <= err_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_oqpsk_rx_deserializer.sv
// Randomized bench for oqpsk_rx_deserializer: builds offset-QPSK sample streams from known words and scores the output.
// Runs an SPS=4 and an SPS=2 instance off shared stimulus, selected per frame.
module tb_oqpsk_rx_deserializer;

    logic        aclk = 1'b0;
    logic        sresetn, start, sel;
    logic [15:0] frame_words;
    logic [23:0] s_tdata;
    logic        s_tvalid, s_tlast;
    logic        m_tready = 1'b1;

    always #5 aclk = ~aclk;

    oqpsk_rx_deserializer_if #(.SAMPLE_WIDTH(12), .TDATA_WIDTH(16)) if4 ();
    oqpsk_rx_deserializer_if #(.SAMPLE_WIDTH(12), .TDATA_WIDTH(16)) if2 ();

    assign if4.s_axis_tdata  = s_tdata;
    assign if4.s_axis_tvalid = s_tvalid && !sel;
    assign if4.s_axis_tlast  = s_tlast;
    assign if4.m_axis_tready = m_tready;
    assign if2.s_axis_tdata  = s_tdata;
    assign if2.s_axis_tvalid = s_tvalid && sel;
    assign if2.s_axis_tlast  = s_tlast;
    assign if2.m_axis_tready = m_tready;

    logic frame_err4, busy4, frame_err2, busy2;
`ifdef OQPSK_RX_ERR_CNT_EN
    logic [15:0] err_count4, err_count2;
`endif

    oqpsk_rx_deserializer #(.SAMPLES_PER_SYMBOL(4), .C_M00_AXIS_TDATA_WIDTH(16), .SAMPLE_WIDTH(12)) dut4 (
        .aclk(aclk), .sresetn(sresetn), .start(start && !sel), .frame_words(frame_words),
        .axis(if4), .frame_err(frame_err4), .busy(busy4)
`ifdef OQPSK_RX_ERR_CNT_EN
        , .err_count(err_count4)
`endif
    );

    oqpsk_rx_deserializer #(.SAMPLES_PER_SYMBOL(2), .C_M00_AXIS_TDATA_WIDTH(16), .SAMPLE_WIDTH(12)) dut2 (
        .aclk(aclk), .sresetn(sresetn), .start(start && sel), .frame_words(frame_words),
        .axis(if2), .frame_err(frame_err2), .busy(busy2)
`ifdef OQPSK_RX_ERR_CNT_EN
        , .err_count(err_count2)
`endif
    );

    wire        s_tready  = sel ? if2.s_axis_tready : if4.s_axis_tready;
    wire        m_tvalid  = sel ? if2.m_axis_tvalid : if4.m_axis_tvalid;
    wire [15:0] m_tdata   = sel ? if2.m_axis_tdata  : if4.m_axis_tdata;
    wire        m_tlast   = sel ? if2.m_axis_tlast  : if4.m_axis_tlast;
    wire        frame_err = sel ? frame_err2 : frame_err4;
    wire        busy      = sel ? busy2 : busy4;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: I symbol k spans samples [k*SPS, (k+1)*SPS), Q symbol k is offset by half a symbol.
    logic [15:0] frame_data[$];
    int          sps_cur = 4;

    function automatic logic data_bit(input int sym, input int rail);
        logic [15:0] w;
        if (sym / 8 >= frame_data.size()) return 1'($urandom);
        w = frame_data[sym / 8];
        return w[2 * (sym % 8) + rail];
    endfunction

    function automatic logic [11:0] level(input logic b);
        case ($urandom % 8)
            0:       return b ? 12'h000 : 12'hFFF;
            1:       return b ? 12'h7FF : 12'h800;
            default: return b ? 12'($urandom_range(0, 2047)) : 12'(4096 - $urandom_range(1, 2048));
        endcase
    endfunction

    function automatic logic [23:0] gen_sample(input int j);
        logic ib, qb;
        ib = data_bit(j / sps_cur, 0);
        qb = (j < sps_cur / 2) ? 1'($urandom) : data_bit((j - sps_cur / 2) / sps_cur, 1);
        return {level(qb), level(ib)};
    endfunction

    logic [16:0] rx_q[$];
    int          err_pulses = 0;
    int          exp_errs[2] = '{0, 0};
    int          stall_word = -1;
    int          stall_left = 0;
    bit          stall_done = 0;
    bit          rand_bp = 0;

    always @(negedge aclk) begin
        if (m_tvalid && m_tready) rx_q.push_back({m_tlast, m_tdata});
        if (frame_err) begin
            err_pulses++;
            chk("busy_at_err", busy, 0);
        end
        if (stall_word >= 0 && !m_tready && m_tvalid) begin
            chk("stall_s_tready", s_tready, 0);
            chk("stall_hold", m_tdata, frame_data[stall_word]);
        end
    end

    always begin
        @(posedge aclk);
        #1;
        if (!stall_done && stall_word >= 0 && m_tvalid && rx_q.size() == stall_word) begin
            stall_done = 1;
            stall_left = 40;
        end
        if (stall_left > 0) begin
            m_tready = 1'b0;
            stall_left--;
        end else begin
            m_tready = rand_bp ? ($urandom % 4 != 0) : 1'b1;
        end
    end

    task automatic run_frame(input int sps, input int nsamp, input int tlast_at, input int rst_at,
                             input int stall_w, input bit bp, input int dup_start_at);
        int  nw, fin, exp_n, exp_err, t;
        bit  aborted, timed_out;
        logic [16:0] r;
        nw = frame_data.size();
        fin = nw * 8 * sps;
        aborted = 0;
        timed_out = 0;
        sel = (sps == 2);
        sps_cur = sps;
        rx_q.delete();
        err_pulses = 0;
        stall_word = stall_w;
        stall_done = 0;
        rand_bp = bp;
        start = 1'b1;
        frame_words = 16'(nw);
        @(posedge aclk); #1;
        start = 1'b0;
        chk("busy_armed", busy, 1);
        for (int j = 0; j < nsamp; j++) begin
            if (j == rst_at) begin
                s_tvalid = 1'b0;
                sresetn = 1'b0;
                repeat (2) @(posedge aclk);
                #1;
                sresetn = 1'b1;
                exp_errs = '{0, 0};
                aborted = 1;
                break;
            end
            if ($urandom % 5 == 0) begin
                s_tvalid = 1'b0;
                @(posedge aclk); #1;
            end
            s_tdata  = gen_sample(j);
            s_tlast  = (j == tlast_at);
            s_tvalid = 1'b1;
            if (j == dup_start_at) begin
                start = 1'b1;
                frame_words = 16'd7;
            end
            t = 0;
            @(negedge aclk);
            while (!s_tready && t < 200) begin
                t++;
                @(negedge aclk);
            end
            if (!s_tready) begin
                chk("accept_timeout", s_tready, 1);
                timed_out = 1;
            end
            @(posedge aclk); #1;
            start = 1'b0;
            if (timed_out) break;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(negedge aclk);
        chk("busy_end", busy, 0);
        if (aborted) chk("rst_abort_tvalid", m_tvalid, 0);
        for (int c = 0; c < 200 && m_tvalid; c++) @(negedge aclk);
        @(negedge aclk);
        rand_bp = 0;

        exp_err = (!aborted && tlast_at < fin) ? 1 : 0;
        exp_n = 0;
        for (int w = 0; w < nw; w++) begin
            if (aborted) begin
                if ((w + 1) * 8 * sps < rst_at) exp_n++;
            end else if (exp_err != 0) begin
                if ((w + 1) * 8 * sps < tlast_at) exp_n++;
            end else begin
                exp_n++;
            end
        end
        exp_errs[sel] += exp_err;
        chk("word_count", rx_q.size(), exp_n);
        for (int i = 0; i < rx_q.size() && i < exp_n; i++) begin
            r = rx_q[i];
            chk($sformatf("word%0d", i), r[15:0], frame_data[i]);
            chk($sformatf("tlast%0d", i), r[16], (exp_err == 0 && !aborted && i == nw - 1) ? 1 : 0);
        end
        chk("frame_err_pulses", err_pulses, exp_err);
`ifdef OQPSK_RX_ERR_CNT_EN
        chk("err_count", sel ? err_count2 : err_count4, exp_errs[sel]);
`endif
        stall_word = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        sresetn = 1'b0;
        start = 1'b0;
        frame_words = '0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tdata = '0;
        sel = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_m_tvalid4", if4.m_axis_tvalid, 0);
        chk("rst_m_tlast4", if4.m_axis_tlast, 0);
        chk("rst_m_tdata4", if4.m_axis_tdata, 0);
        chk("rst_s_tready4", if4.s_axis_tready, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_frame_err4", frame_err4, 0);
        chk("rst_m_tvalid2", if2.m_axis_tvalid, 0);
        chk("rst_s_tready2", if2.s_axis_tready, 0);
        chk("rst_busy2", busy2, 0);
`ifdef OQPSK_RX_ERR_CNT_EN
        chk("rst_err_count4", err_count4, 0);
`endif
        @(posedge aclk); #1;
        sresetn = 1'b1;

        // Zero-length frame never leaves IDLE
        start = 1'b1;
        frame_words = 16'd0;
        @(posedge aclk); #1;
        start = 1'b0;
        @(negedge aclk);
        chk("zero_len_busy", busy, 0);
        @(posedge aclk); #1;

        frame_data = '{16'hA5C3};
        run_frame(4, 66, 65, -1, -1, 0, -1);

        frame_data = '{16'h0000, 16'hFFFF, 16'h1234};
        run_frame(4, 97, 96, -1, -1, 0, 10);

        frame_data = '{16'($urandom), 16'($urandom), 16'($urandom)};
        run_frame(4, 97, 96, -1, 1, 0, -1);

        frame_data = '{16'($urandom), 16'($urandom)};
        run_frame(4, 65, 64, 20, -1, 0, -1);
        frame_data = '{16'hBEEF};
        run_frame(4, 33, 32, -1, -1, 0, -1);

        frame_data = '{16'($urandom), 16'($urandom)};
        run_frame(4, 41, 40, -1, -1, 0, -1);

        frame_data = '{16'h8001};
        run_frame(2, 17, 16, -1, -1, 0, -1);

        for (int f = 0; f < 8; f++) begin
            int sps, nw, extra;
            sps = ($urandom % 2 == 0) ? 2 : 4;
            nw = $urandom_range(1, 3);
            extra = $urandom_range(0, 10);
            frame_data.delete();
            for (int w = 0; w < nw; w++) frame_data.push_back(16'($urandom));
            run_frame(sps, nw * 8 * sps + 1 + extra, nw * 8 * sps + extra, -1, -1, 1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
